// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle two's-complement adder/subtractor.
// Processes DIGIT bits per clock, LSB digit first, through a registered carry.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            request, accepted in IDLE or DONE
//   sub, acc, A, B   operation controls and operands, sampled with start
//   busy             high while calculating
//   done             one-cycle completion pulse
//   S                result register
//   cout, ovf        carry out of the MSB, signed overflow
//   zero, neg        S == 0, S[WIDTH-1]
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             acc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned DW   = DIGIT + 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Digit adder: operands are shifted right each cycle so the live digit is
  // always at the bottom; the sum digit enters the working result at the top.
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DW-1:0]    dsum;
  logic             c_into_msb;
  logic [WIDTH-1:0] work_next;

  always_comb begin
    a_dig      = opa_q[DIGIT-1:0];
    b_dig      = opb_q[DIGIT-1:0];
    dsum       = {1'b0, a_dig} + {1'b0, b_dig} + DW'(carry_q);
    // Carry into the digit's top bit recovered from its sum bit and inputs.
    c_into_msb = dsum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    work_next  = (work_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    work_d  = work_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = acc ? s_q : A;
          opb_d   = sub ? ~B : B;
          carry_d = sub;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        work_d  = work_next;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          s_d     = work_next;
          cout_d  = dsum[DIGIT];
          ovf_d   = c_into_msb ^ dsum[DIGIT];
          zero_d  = (work_next == '0);
          neg_d   = work_next[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed and random operations on an 8/2 instance
// plus random sweeps on 8/1, 8/4, 8/8 and 16/4 instances, all checked by a
// queue-based scoreboard against an integer reference model.
module tb_serial_add_sub;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int ND = W / D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint s;
    bit     cout;
    bit     ovf;
    bit     zero;
    bit     neg;
    longint t0;
  } exp_t;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic modulo 2^w.
  function automatic exp_t model(input int w, input longint a, input longint b,
                                 input bit sb, input longint t0);
    exp_t   e;
    longint m, half, sa, sbv, r, u;
    m    = longint'(1) << w;
    half = m >> 1;
    sa   = (a >= half) ? a - m : a;
    sbv  = (b >= half) ? b - m : b;
    r    = sb ? sa - sbv : sa + sbv;
    u    = sb ? a - b : a + b;
    e.s    = ((u % m) + m) % m;
    e.cout = sb ? (a >= b) : (u >= m);
    e.ovf  = (r < -half) || (r >= half);
    e.zero = (e.s == 0);
    e.neg  = (e.s >= half);
    e.t0   = t0;
    return e;
  endfunction

  // ---------------- main 8/2 instance ----------------
  logic         rst, start, sub, acc;
  logic [W-1:0] A, B, S;
  logic         busy, done, cout, ovf, zero, neg;

  serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .acc  (acc),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .S    (S),
    .cout (cout),
    .ovf  (ovf),
    .zero (zero),
    .neg  (neg)
  );

  exp_t   q[$];
  longint s_model = 0;
  bit     rst_at_edge = 1'b1;
  always @(posedge clk) rst_at_edge <= rst;

  // Issue one op; noise pulses start with junk inputs during CALC.
  task automatic issue(input longint a, input longint b, input bit sb, input bit ac,
                       input bit noise, input int gap);
    exp_t   e;
    longint opa;
    start = 1'b1; A = W'(a); B = W'(b); sub = sb; acc = ac;
    @(posedge clk); #1;
    opa = ac ? s_model : a;
    e = model(W, opa, b, sb, cyc);
    q.push_back(e);
    s_model = e.s;
    for (int i = 0; i < ND; i++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      A = W'($urandom); B = W'($urandom); sub = 1'($urandom); acc = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_main", q.size(), 0);
  endtask

  // Monitor: pops on done, checks flags, latency, busy length, S stability.
  int   busy_run = 0;
  logic [W-1:0] prev_s;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      busy_run  = 0;
      prev_s    = S;
      prev_done = done;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        check("busy_len", busy_run, ND);
        busy_run = 0;
      end
      if (done) begin
        check("done_pulse", prev_done, 0);
        if (q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          check("S", S, e.s);
          check("cout", cout, e.cout);
          check("ovf", ovf, e.ovf);
          check("zero", zero, e.zero);
          check("neg", neg, e.neg);
          check("latency", cyc - e.t0, ND);
        end
      end else begin
        check("s_stable", S, prev_s);
      end
      prev_s    = S;
      prev_done = done;
    end
  end

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : sweep
    localparam int SW = (g == 3) ? 16 : 8;
    localparam int SD = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 4;
    localparam int SN = SW / SD;

    logic          srst, sstart, ssub, sacc, sbusy, sdone, scout, sovf, szero, sneg;
    logic [SW-1:0] sa, sb, ss;
    bit            fin = 1'b0;
    bit            rae = 1'b1;
    exp_t          sq[$];

    serial_add_sub #(.WIDTH(SW), .DIGIT(SD)) u_dut (
      .clk  (clk),
      .rst  (srst),
      .start(sstart),
      .sub  (ssub),
      .acc  (sacc),
      .A    (sa),
      .B    (sb),
      .busy (sbusy),
      .done (sdone),
      .S    (ss),
      .cout (scout),
      .ovf  (sovf),
      .zero (szero),
      .neg  (sneg)
    );

    always @(posedge clk) rae <= srst;

    initial begin
      logic [SW-1:0] a, b;
      bit            s;
      srst = 1'b1; sstart = 1'b0; ssub = 1'b0; sacc = 1'b0; sa = '0; sb = '0;
      repeat (2) @(posedge clk);
      #1 srst = 1'b0;
      repeat (1000) begin
        a = SW'($urandom); b = SW'($urandom); s = 1'($urandom);
        sstart = 1'b1; sa = a; sb = b; ssub = s;
        @(posedge clk); #1;
        sq.push_back(model(SW, longint'(a), longint'(b), s, cyc));
        sstart = 1'b0;
        repeat (SN) @(posedge clk);
        #1;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
      for (int i = 0; i < 100 && sq.size() != 0; i++) @(posedge clk);
      #1;
      check($sformatf("drain_w%0dd%0d", SW, SD), sq.size(), 0);
      fin = 1'b1;
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rae && sdone) begin
        if (sq.size() == 0) check($sformatf("unexp_w%0dd%0d", SW, SD), 1, 0);
        else begin
          e = sq.pop_front();
          check($sformatf("S_w%0dd%0d", SW, SD), ss, e.s);
          check($sformatf("cout_w%0dd%0d", SW, SD), scout, e.cout);
          check($sformatf("ovf_w%0dd%0d", SW, SD), sovf, e.ovf);
          check($sformatf("lat_w%0dd%0d", SW, SD), cyc - e.t0, SN);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; acc = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_S", S, 0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_neg", neg, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    issue(100, 27, 0, 0, 0, 2);
    issue(100, 28, 0, 0, 0, 1);
    issue(8'hFF, 1, 0, 0, 0, 1);
    issue(5, 7, 1, 0, 0, 1);
    issue(8'h80, 1, 1, 0, 0, 1);
    // Accumulate back-to-back: 0x7F then S - 3
    issue(8'h7F, 0, 0, 0, 0, 0);
    issue(8'hA5, 3, 1, 1, 0, 2);
    // start pulsed during CALC must be ignored
    issue(100, 27, 0, 0, 1, 1);
    drain();

    // Reset in the second CALC cycle
    start = 1'b1; A = 8'h55; B = 8'h11; sub = 1'b0; acc = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_model = 0;
    @(negedge clk);
    check("midrst_S", S, 0);
    check("midrst_zero", zero, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(posedge clk); #1;
    issue(8'h12, 8'h34, 0, 1, 0, 1);

    // Random traffic including accumulate, noise and back-to-back
    repeat (300)
      issue(longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)),
            1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    drain();

    for (int i = 0; i < 50000 &&
         !(sweep[0].fin && sweep[1].fin && sweep[2].fin && sweep[3].fin); i++)
      @(posedge clk);
    #1;
    check("sweep_finished",
          longint'(sweep[0].fin && sweep[1].fin && sweep[2].fin && sweep[3].fin), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
